// File: rtl/multi_clk_divider_if.sv
// Bus bundle for multi_clk_divider: per-channel enables/modes, the divisor
// write port and the per-channel divided outputs.
interface multi_clk_divider_if #(
   parameter int CNT_W  = 10,
   parameter int NUM_CH = 2,
   parameter int SEL_W  = 1
);
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic              div_wr;
   logic [SEL_W-1:0]  div_ch;
   logic [CNT_W-1:0]  div_val;
   logic [NUM_CH-1:0] divided_clk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;

   // Controller side: drives enables, modes and divisor writes.
   modport master (
      output en, mode, div_wr, div_ch, div_val,
      input  divided_clk, tick, pending
   );

   // Divider side.
   modport slave (
      input  en, mode, div_wr, div_ch, div_val,
      output divided_clk, tick, pending
   );
endinterface

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider. Each channel counts 0..D and
// fires a terminal event; the output is either a 50% toggle or a one-cycle
// strobe. Divisor writes go to a shadow register and are promoted to the
// active divisor only at a terminal event (or immediately while disabled),
// so a running output never sees a truncated or stretched period mid-phase.
module multi_clk_divider #(
   parameter int CNT_W       = 10,
   parameter int NUM_CH      = 2,
   parameter int DEFAULT_DIV = 1000,
   parameter int SEL_W       = 1
) (
   input  logic               clk_in,
   input  logic               rst,
   multi_clk_divider_if.slave bus
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0]  cnt_q     [NUM_CH];
   logic [CNT_W-1:0]  cnt_d     [NUM_CH];
   logic [CNT_W-1:0]  act_div_q [NUM_CH];
   logic [CNT_W-1:0]  act_div_d [NUM_CH];
   logic [CNT_W-1:0]  sh_div_q  [NUM_CH];
   logic [CNT_W-1:0]  sh_div_d  [NUM_CH];
   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] pending_d;
   logic [NUM_CH-1:0] div_clk_q;
   logic [NUM_CH-1:0] div_clk_d;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] tick_d;

   logic [NUM_CH-1:0] term_s;
   logic [NUM_CH-1:0] wr_hit_s;

   // Terminal-event and write-select decode; out-of-range div_ch matches no channel.
   always_comb begin
      term_s   = '0;
      wr_hit_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         term_s[i]   = bus.en[i] && (cnt_q[i] == act_div_q[i]);
         wr_hit_s[i] = bus.div_wr && (bus.div_ch == SEL_W'(i));
      end
   end

   // Per-channel next state: counter, shadow promotion, write capture, outputs.
   always_comb begin
      pending_d = pending_q;
      div_clk_d = div_clk_q;
      tick_d    = term_s;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]     = cnt_q[i];
         act_div_d[i] = act_div_q[i];
         sh_div_d[i]  = sh_div_q[i];

         if (bus.en[i]) begin
            if (term_s[i]) begin
               cnt_d[i] = '0;
               if (pending_q[i]) begin
                  act_div_d[i] = sh_div_q[i];
                  pending_d[i] = 1'b0;
               end else begin
                  act_div_d[i] = act_div_q[i];
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Pulse mode follows term directly; toggle mode flips on term.
            if (bus.mode[i]) begin
               div_clk_d[i] = term_s[i];
            end else begin
               div_clk_d[i] = div_clk_q[i] ^ term_s[i];
            end
         end else begin
            // Disabled: output holds; a pending divisor restarts the channel at phase 0.
            div_clk_d[i] = div_clk_q[i];
            if (pending_q[i]) begin
               act_div_d[i] = sh_div_q[i];
               cnt_d[i]     = '0;
               pending_d[i] = 1'b0;
            end else begin
               cnt_d[i] = cnt_q[i];
            end
         end

         // A write lands after any promotion above, so on a collision the
         // old shadow becomes active and the new value stays pending.
         if (wr_hit_s[i]) begin
            sh_div_d[i]  = bus.div_val;
            pending_d[i] = 1'b1;
         end else begin
            sh_div_d[i] = sh_div_q[i];
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]     <= '0;
            act_div_q[i] <= DEF_DIV;
            sh_div_q[i]  <= DEF_DIV;
         end
         pending_q <= '0;
         div_clk_q <= '0;
         tick_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         act_div_q <= act_div_d;
         sh_div_q  <= sh_div_d;
         pending_q <= pending_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
      end
   end

   assign bus.divided_clk = div_clk_q;
   assign bus.tick        = tick_q;
   assign bus.pending     = pending_q;

endmodule
